// File: rtl/branch_pc_pkg.sv
// ---------------------------------------------------------------------------
// branch_pc_pkg
// Shared definitions for the branch/PC stage and the instruction decoder:
//   - BranchCond encodings (COND_*)
//   - lifecycle state enum (IDLE -> RUN -> HALTED)
//   - cond_true(): evaluates a branch condition against registered flags
// ---------------------------------------------------------------------------
package branch_pc_pkg;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_LT     = 2'b10;
    localparam logic [1:0] COND_NZ     = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    // Branch condition mux; callers must pass the registered flags.
    function automatic logic cond_true(input logic [1:0] cond,
                                       input logic       flag_z,
                                       input logic       flag_lt);
        logic res;
        case (cond)
            COND_ALWAYS: res = 1'b1;
            COND_Z:      res = flag_z;
            COND_LT:     res = flag_lt;
            COND_NZ:     res = ~flag_z;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_pc_unit.sv
// ---------------------------------------------------------------------------
// branch_pc_unit
// Program-counter and flag stage downstream of the ALU. Latches ALU Zero/LT
// into a flag register, resolves conditional branches against those
// registered flags, sequences IDLE -> RUN -> HALTED with a Start/Done
// handshake and counts RUN cycles since the last Start.
//
// Ports:
//   Clk, Reset_n           clock (rising edge), async active-low reset
//   Start, StartAddr       begin program at StartAddr (IDLE/HALTED only)
//   Zero, LT, FlagWe       ALU status and flag-register write enable
//   Branch, BranchCond,
//   BranchTarget           conditional absolute branch
//   Halt                   current instruction is halt
//   ProgCtr                current instruction address
//   FlagZ, FlagLT          registered flags
//   Running, Done          state == RUN / state == HALTED
//   CycleCount             saturating RUN-cycle counter
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module branch_pc_unit
    import branch_pc_pkg::*;
#(
    parameter int PW = 10,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic          Zero,
    input  logic          LT,
    input  logic          FlagWe,
    input  logic          Branch,
    input  logic [1:0]    BranchCond,
    input  logic [PW-1:0] BranchTarget,
    input  logic          Halt,
    output logic [PW-1:0] ProgCtr,
    output logic          FlagZ,
    output logic          FlagLT,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    localparam logic [PW-1:0] PC_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_r,   state_s;
    logic [PW-1:0] pc_r,      pc_s;
    logic          flag_z_r,  flag_z_s;
    logic          flag_lt_r, flag_lt_s;
    logic [CW-1:0] cnt_r,     cnt_s;
    logic          running_r, done_r;
    logic          take_s;

    // Branch decision from registered flags only (same-cycle FlagWe not seen).
    always_comb begin
        take_s = Branch & cond_true(BranchCond, flag_z_r, flag_lt_r);
    end

    // Next-state, next-PC, flag and counter logic.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        flag_z_s  = flag_z_r;
        flag_lt_s = flag_lt_r;
        cnt_s     = cnt_r;
        case (state_r)
            IDLE, HALTED: begin
                if (Start) begin
                    state_s   = RUN;
                    pc_s      = StartAddr;
                    flag_z_s  = 1'b0;
                    flag_lt_s = 1'b0;
                    cnt_s     = {CW{1'b0}};
                end else begin
                    state_s   = state_r;
                end
            end
            RUN: begin
                if (FlagWe) begin
                    flag_z_s  = Zero;
                    flag_lt_s = LT;
                end else begin
                    flag_z_s  = flag_z_r;
                end
                if (cnt_r != CNT_MAX) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
                // Halt outranks any branch; PC stays on the halt instruction.
                if (Halt) begin
                    state_s = HALTED;
                end else if (take_s) begin
                    pc_s = BranchTarget;
                end else begin
                    pc_s = pc_r + PC_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; Running/Done registered from next state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= IDLE;
            pc_r      <= {PW{1'b0}};
            flag_z_r  <= 1'b0;
            flag_lt_r <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            flag_z_r  <= flag_z_s;
            flag_lt_r <= flag_lt_s;
            cnt_r     <= cnt_s;
            running_r <= (state_s == RUN);
            done_r    <= (state_s == HALTED);
        end
    end

    assign ProgCtr    = pc_r;
    assign FlagZ      = flag_z_r;
    assign FlagLT     = flag_lt_r;
    assign Running    = running_r;
    assign Done       = done_r;
    assign CycleCount = cnt_r;

endmodule

// File: tb/tb_branch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_pc_unit
// Directed-vector bench for branch_pc_unit (PW=10, CW=16) with
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_branch_pc_unit;
    import branch_pc_pkg::*;

    localparam int PW = 10;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Start;
    logic [PW-1:0] StartAddr;
    logic          Zero, LT, FlagWe, Branch, Halt;
    logic [1:0]    BranchCond;
    logic [PW-1:0] BranchTarget;
    logic [PW-1:0] ProgCtr;
    logic          FlagZ, FlagLT, Running, Done;
    logic [CW-1:0] CycleCount;

    int n_checks = 0;
    int n_errors = 0;

    branch_pc_unit #(.PW(PW), .CW(CW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .Zero(Zero), .LT(LT), .FlagWe(FlagWe), .Branch(Branch),
        .BranchCond(BranchCond), .BranchTarget(BranchTarget), .Halt(Halt),
        .ProgCtr(ProgCtr), .FlagZ(FlagZ), .FlagLT(FlagLT), .Running(Running),
        .Done(Done), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        Start = 1'b0; StartAddr = '0; Zero = 1'b0; LT = 1'b0; FlagWe = 1'b0;
        Branch = 1'b0; BranchCond = COND_ALWAYS; BranchTarget = '0; Halt = 1'b0;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clk);
        #1;
        idle_inputs();
    endtask

    task automatic check_all(input string tag, input logic [PW-1:0] pc,
                             input logic fz, input logic flt, input logic run,
                             input logic dn, input logic [CW-1:0] cnt);
        check_val({tag, ".pc"},   32'(ProgCtr),    32'(pc));
        check_val({tag, ".fz"},   32'(FlagZ),      32'(fz));
        check_val({tag, ".flt"},  32'(FlagLT),     32'(flt));
        check_val({tag, ".run"},  32'(Running),    32'(run));
        check_val({tag, ".done"}, 32'(Done),       32'(dn));
        check_val({tag, ".cnt"},  32'(CycleCount), 32'(cnt));
    endtask

    initial begin
        idle_inputs();
        Reset_n = 1'b0;
        #12;
        check_all("reset", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        Reset_n = 1'b1;
        step();
        check_all("idle_hold", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Start at 0x010, run one cycle, then reset mid-run.
        Start = 1'b1; StartAddr = 10'h010;
        step();
        check_all("start010", 10'h010, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        FlagWe = 1'b1; Zero = 1'b1; LT = 1'b1;
        step();
        check_all("run1", 10'h011, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1);
        #2 Reset_n = 1'b0;
        #1;
        check_all("async_rst", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        #1 Reset_n = 1'b1;

        // Sequential wrap from 0x3FE.
        Start = 1'b1; StartAddr = 10'h3FE;
        step();
        check_all("start3fe", 10'h3FE, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        step(); check_val("wrap1.pc", 32'(ProgCtr), 32'h3FF);
        step(); check_val("wrap2.pc", 32'(ProgCtr), 32'h000);
        step(); check_val("wrap3.pc", 32'(ProgCtr), 32'h001);
        check_val("wrap.cnt", 32'(CycleCount), 32'd3);

        // Flag write then COND_Z branch taken, COND_LT not taken.
        FlagWe = 1'b1; Zero = 1'b1; LT = 1'b0;
        step();
        check_all("flagwe", 10'h002, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
        Branch = 1'b1; BranchCond = COND_Z; BranchTarget = 10'h040;
        step();
        check_val("brz.pc", 32'(ProgCtr), 32'h040);
        Branch = 1'b1; BranchCond = COND_LT; BranchTarget = 10'h080;
        step();
        check_val("brlt.pc", 32'(ProgCtr), 32'h041);

        // Clear FlagZ, then same-cycle FlagWe + Branch hazard.
        FlagWe = 1'b1; Zero = 1'b0; LT = 1'b1;
        step();
        check_all("clrz", 10'h042, 1'b0, 1'b1, 1'b1, 1'b0, 16'd7);
        FlagWe = 1'b1; Zero = 1'b1; LT = 1'b0;
        Branch = 1'b1; BranchCond = COND_Z; BranchTarget = 10'h080;
        step();
        check_all("hazard", 10'h043, 1'b1, 1'b0, 1'b1, 1'b0, 16'd8);

        // COND_NZ with FlagZ=1 not taken; COND_ALWAYS to 0x025.
        Branch = 1'b1; BranchCond = COND_NZ; BranchTarget = 10'h200;
        step();
        check_val("brnz.pc", 32'(ProgCtr), 32'h044);
        Branch = 1'b1; BranchCond = COND_ALWAYS; BranchTarget = 10'h025;
        step();
        check_val("bral.pc", 32'(ProgCtr), 32'h025);

        // Start ignored in RUN.
        Start = 1'b1; StartAddr = 10'h155;
        step();
        check_all("run_start", 10'h026, 1'b1, 1'b0, 1'b1, 1'b0, 16'd11);
        Branch = 1'b1; BranchCond = COND_ALWAYS; BranchTarget = 10'h025;
        step();
        check_val("bral2.pc", 32'(ProgCtr), 32'h025);

        // Halt beats Branch.
        Halt = 1'b1; Branch = 1'b1; BranchCond = COND_ALWAYS; BranchTarget = 10'h100;
        step();
        check_all("halt", 10'h025, 1'b1, 1'b0, 1'b0, 1'b1, 16'd13);

        // Ignored inputs in HALTED.
        FlagWe = 1'b1; Zero = 1'b0; LT = 1'b1;
        Branch = 1'b1; BranchCond = COND_ALWAYS; BranchTarget = 10'h300; Halt = 1'b1;
        step();
        check_all("halted_ign", 10'h025, 1'b1, 1'b0, 1'b0, 1'b1, 16'd13);

        // Restart from HALTED.
        Start = 1'b1; StartAddr = 10'h000;
        step();
        check_all("restart", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        step();
        check_all("restart_run", 10'h001, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
